time_set_ctl: RTL and testbench

- Sequences manual setting of the time/date counter datapath from two debounced, one-pulsed push buttons.
- Captures the running counter values and lets the user step through the fields hour, minute, year, month, day, incrementing each with wrap and calendar checks.
- On commit, presents the edited BCD values with a one-cycle load strobe to the counters.
- Freezes the counters and drives blink control to the display mux while editing; runs in the 100 Hz debounce clock domain.

---
 rtl/time_set_ctl_if.sv | 35 +++
 rtl/time_set_ctl.sv | 210 +++++++++++++++++++++
 tb/tb_time_set_ctl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/time_set_ctl_if.sv
// Bundle between the push-button/counter side and the time-set controller.
// master drives pulses and running values; slave (the controller) returns edited values and status.
interface time_set_ctl_if;
    logic       set_pulse;
    logic       inc_pulse;
    logic       inc_level;
    logic [7:0] cur_hour;
    logic [7:0] cur_min;
    logic [7:0] cur_year;
    logic [7:0] cur_mon;
    logic [7:0] cur_day;
    logic [7:0] set_hour;
    logic [7:0] set_min;
    logic [7:0] set_year;
    logic [7:0] set_mon;
    logic [7:0] set_day;
    logic       load;
    logic       setting;
    logic [2:0] field;
    logic       blink_on;

    modport master (
        output set_pulse, inc_pulse, inc_level,
        output cur_hour, cur_min, cur_year, cur_mon, cur_day,
        input  set_hour, set_min, set_year, set_mon, set_day,
        input  load, setting, field, blink_on
    );

    modport slave (
        input  set_pulse, inc_pulse, inc_level,
        input  cur_hour, cur_min, cur_year, cur_mon, cur_day,
        output set_hour, set_min, set_year, set_mon, set_day,
        output load, setting, field, blink_on
    );
endinterface

// File: rtl/time_set_ctl.sv
// Manual time/date setting sequencer: capture, per-field BCD edit with calendar checks, commit strobe.
// Optional AUTO_REPEAT_EN macro enables held-button auto-repeat increments from inc_level.
module time_set_ctl #(
    parameter int TIMEOUT      = 3000,
    parameter int BLINK_HALF   = 50,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic           clk,
    input  logic           rst,
    time_set_ctl_if.slave  bus
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int BL_W = $clog2(BLINK_HALF + 1);

    // Edit-state encodings double as the field number shown to the display mux
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_HOUR = 3'd1,
        S_MIN  = 3'd2,
        S_YEAR = 3'd3,
        S_MON  = 3'd4,
        S_DAY  = 3'd5,
        COMMIT = 3'd6
    } state_t;

    state_t state_reg, state_next;
    logic [7:0] hour_reg, hour_next;
    logic [7:0] min_reg,  min_next;
    logic [7:0] year_reg, year_next;
    logic [7:0] mon_reg,  mon_next;
    logic [7:0] day_reg,  day_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic [BL_W-1:0] blink_cnt_reg, blink_cnt_next;
    logic blink_phase_reg, blink_phase_next;
    logic edit;
    logic rep_fire;
    logic inc_evt;
    logic [7:0] dmax;

    // Illegal digits or values at/above the field maximum wrap to the minimum
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v,
                                           input logic [7:0] min_v);
        if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || v >= max_v)
            return min_v;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Decimal value divisible by 4: even tens need units 0/4/8, odd tens need units 2/6
    function automatic logic is_leap(input logic [7:0] y);
        if (y[4])
            return (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
        else
            return (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [7:0] y);
        case (m)
            8'h02:                      return is_leap(y) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    assign edit    = (state_reg >= S_HOUR) && (state_reg <= S_DAY);
    assign dmax    = days_in_month(mon_reg, year_reg);
    assign inc_evt = bus.inc_pulse | rep_fire;

`ifdef AUTO_REPEAT_EN
    localparam int RP_W = $clog2(REPEAT_DELAY + 1);
    logic [RP_W-1:0] rep_cnt_reg, rep_cnt_next;

    // After the first repeat, re-arm REPEAT_RATE cycles short of the delay threshold
    always_comb begin
        rep_cnt_next = '0;
        rep_fire     = 1'b0;
        if (edit && bus.inc_level && !bus.set_pulse) begin
            if (rep_cnt_reg == RP_W'(REPEAT_DELAY - 1)) begin
                rep_fire     = 1'b1;
                rep_cnt_next = RP_W'(REPEAT_DELAY - REPEAT_RATE);
            end else begin
                rep_cnt_next = rep_cnt_reg + RP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rep_cnt_reg <= '0;
        else
            rep_cnt_reg <= rep_cnt_next;
    end
`else
    logic unused_inc_level;
    assign unused_inc_level = bus.inc_level;
    assign rep_fire         = 1'b0;
`endif

    always_comb begin
        state_next       = state_reg;
        hour_next        = hour_reg;
        min_next         = min_reg;
        year_next        = year_reg;
        mon_next         = mon_reg;
        day_next         = day_reg;
        to_cnt_next      = '0;
        blink_cnt_next   = '0;
        blink_phase_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.set_pulse) begin
                    hour_next  = bus.cur_hour;
                    min_next   = bus.cur_min;
                    year_next  = bus.cur_year;
                    mon_next   = bus.cur_mon;
                    day_next   = bus.cur_day;
                    state_next = S_HOUR;
                end
            end
            S_HOUR: begin
                if (bus.set_pulse)  state_next = S_MIN;
                else if (inc_evt)   hour_next  = bcd_inc(hour_reg, 8'h23, 8'h00);
            end
            S_MIN: begin
                if (bus.set_pulse)  state_next = S_YEAR;
                else if (inc_evt)   min_next   = bcd_inc(min_reg, 8'h59, 8'h00);
            end
            S_YEAR: begin
                if (bus.set_pulse) begin
                    state_next = S_MON;
                    day_next   = (day_reg > dmax) ? dmax : day_reg;
                end else if (inc_evt) begin
                    year_next  = bcd_inc(year_reg, 8'h99, 8'h00);
                end
            end
            S_MON: begin
                if (bus.set_pulse) begin
                    state_next = S_DAY;
                    day_next   = (day_reg > dmax) ? dmax : day_reg;
                end else if (inc_evt) begin
                    mon_next   = bcd_inc(mon_reg, 8'h12, 8'h01);
                end
            end
            S_DAY: begin
                if (bus.set_pulse)  state_next = COMMIT;
                else if (inc_evt)   day_next   = bcd_inc(day_reg, dmax, 8'h01);
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Abort without load after TIMEOUT pulse-free cycles in any edit state
        if (edit && !bus.set_pulse && !inc_evt) begin
            if (to_cnt_reg == TO_W'(TIMEOUT - 1))
                state_next = IDLE;
            else
                to_cnt_next = to_cnt_reg + TO_W'(1);
        end

        // Blink restarts visible on any field change or increment
        if (edit && (state_next == state_reg) && !inc_evt) begin
            if (blink_cnt_reg == BL_W'(BLINK_HALF - 1)) begin
                blink_phase_next = ~blink_phase_reg;
            end else begin
                blink_cnt_next   = blink_cnt_reg + BL_W'(1);
                blink_phase_next = blink_phase_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            hour_reg        <= 8'h00;
            min_reg         <= 8'h00;
            year_reg        <= 8'h00;
            mon_reg         <= 8'h01;
            day_reg         <= 8'h01;
            to_cnt_reg      <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            hour_reg        <= hour_next;
            min_reg         <= min_next;
            year_reg        <= year_next;
            mon_reg         <= mon_next;
            day_reg         <= day_next;
            to_cnt_reg      <= to_cnt_next;
            blink_cnt_reg   <= blink_cnt_next;
            blink_phase_reg <= blink_phase_next;
        end
    end

    assign bus.set_hour = hour_reg;
    assign bus.set_min  = min_reg;
    assign bus.set_year = year_reg;
    assign bus.set_mon  = mon_reg;
    assign bus.set_day  = day_reg;
    assign bus.load     = (state_reg == COMMIT);
    assign bus.setting  = (state_reg != IDLE);
    assign bus.field    = edit ? 3'(state_reg) : 3'd0;
    assign bus.blink_on = blink_phase_reg & edit;

endmodule

// File: tb/tb_time_set_ctl.sv
// Directed self-checking bench for time_set_ctl: reset, edit/commit, calendar clamps, wraps, timeout, blink.
module tb_time_set_ctl;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    logic load_seen;

    always #5 clk = ~clk;

    time_set_ctl_if bus ();

    time_set_ctl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
        $display("[%0t] check %s observed=%02h expected=%02h", $time, tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_set();
        bus.set_pulse = 1'b1;
        tick();
        bus.set_pulse = 1'b0;
    endtask

    task automatic press_inc();
        bus.inc_pulse = 1'b1;
        tick();
        bus.inc_pulse = 1'b0;
    endtask

    task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic [7:0] y,
                           input logic [7:0] mo, input logic [7:0] d);
        bus.cur_hour = h;
        bus.cur_min  = m;
        bus.cur_year = y;
        bus.cur_mon  = mo;
        bus.cur_day  = d;
    endtask

    // Leave an edit state by advancing through COMMIT back to IDLE
    task automatic exit_edit(input int fld);
        repeat (6 - fld) press_set();
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        bus.set_pulse = 1'b0;
        bus.inc_pulse = 1'b0;
        bus.inc_level = 1'b0;
        set_cur(8'h00, 8'h00, 8'h00, 8'h01, 8'h01);
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("rst_setting",  {7'd0, bus.setting},  8'h00);
        check("rst_field",    {5'd0, bus.field},    8'h00);
        check("rst_load",     {7'd0, bus.load},     8'h00);
        check("rst_blink",    {7'd0, bus.blink_on}, 8'h00);
        check("rst_hour",     bus.set_hour,         8'h00);
        check("rst_mon",      bus.set_mon,          8'h01);
        check("rst_day",      bus.set_day,          8'h01);

        // Reset during S_MIN aborts without load
        set_cur(8'h12, 8'h34, 8'h23, 8'h05, 8'h10);
        press_set();
        press_inc();
        press_set();
        check("mid_field",    {5'd0, bus.field},    8'h02);
        check("mid_hour",     bus.set_hour,         8'h13);
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        check("arst_setting", {7'd0, bus.setting},  8'h00);
        check("arst_field",   {5'd0, bus.field},    8'h00);
        check("arst_hour",    bus.set_hour,         8'h00);
        check("arst_min",     bus.set_min,          8'h00);
        check("arst_mon",     bus.set_mon,          8'h01);
        check("arst_day",     bus.set_day,          8'h01);
        load_seen = 1'b0;
        repeat (3) begin
            tick();
            load_seen = load_seen | bus.load;
        end
        check("arst_noload",  {7'd0, load_seen},    8'h00);

        // 23:59 wraps to 00:00 and commits with a single-cycle load
        set_cur(8'h23, 8'h59, 8'h23, 8'h02, 8'h15);
        press_set();
        check("cap_hour",     bus.set_hour,         8'h23);
        check("cap_setting",  {7'd0, bus.setting},  8'h01);
        press_inc();
        check("hour_wrap",    bus.set_hour,         8'h00);
        press_set();
        press_inc();
        check("min_wrap",     bus.set_min,          8'h00);
        press_set();
        press_set();
        press_set();
        check("pre_load",     {7'd0, bus.load},     8'h00);
        check("day_field",    {5'd0, bus.field},    8'h05);
        press_set();
        check("load_hi",      {7'd0, bus.load},     8'h01);
        check("load_setting", {7'd0, bus.setting},  8'h01);
        check("load_hour",    bus.set_hour,         8'h00);
        check("load_min",     bus.set_min,          8'h00);
        check("load_year",    bus.set_year,         8'h23);
        check("load_mon",     bus.set_mon,          8'h02);
        check("load_day",     bus.set_day,          8'h15);
        tick();
        check("load_lo",      {7'd0, bus.load},     8'h00);
        check("post_setting", {7'd0, bus.setting},  8'h00);

        // inc in IDLE is ignored
        press_inc();
        check("idle_inc",     bus.set_hour,         8'h00);
        check("idle_setting", {7'd0, bus.setting},  8'h00);

        // Day clamp to Feb length on leaving S_MON, non-leap then leap
        set_cur(8'h10, 8'h10, 8'h23, 8'h01, 8'h31);
        repeat (4) press_set();
        press_inc();
        check("mon_inc",      bus.set_mon,          8'h02);
        press_set();
        check("clamp_28",     bus.set_day,          8'h28);
        exit_edit(5);
        set_cur(8'h10, 8'h10, 8'h24, 8'h01, 8'h31);
        repeat (4) press_set();
        press_inc();
        press_set();
        check("clamp_29",     bus.set_day,          8'h29);
        exit_edit(5);

        // Day wrap at month end
        set_cur(8'h10, 8'h10, 8'h23, 8'h04, 8'h30);
        repeat (5) press_set();
        press_inc();
        check("day_wrap_30",  bus.set_day,          8'h01);
        exit_edit(5);
        set_cur(8'h10, 8'h10, 8'h23, 8'h12, 8'h31);
        repeat (5) press_set();
        press_inc();
        check("day_wrap_31",  bus.set_day,          8'h01);
        exit_edit(5);

        // Illegal captured digit wraps; minute carry into tens
        set_cur(8'h1F, 8'h09, 8'h99, 8'h12, 8'h01);
        press_set();
        press_inc();
        check("illegal_hour", bus.set_hour,         8'h00);
        press_set();
        press_inc();
        check("min_carry",    bus.set_min,          8'h10);
        press_set();
        press_inc();
        check("year_wrap",    bus.set_year,         8'h00);
        press_set();
        press_inc();
        check("mon_wrap",     bus.set_mon,          8'h01);
        exit_edit(4);

        // Simultaneous set+inc: set wins; then timeout with blink observed along the way
        set_cur(8'h05, 8'h20, 8'h23, 8'h03, 8'h03);
        press_set();
        bus.set_pulse = 1'b1;
        bus.inc_pulse = 1'b1;
        tick();
        bus.set_pulse = 1'b0;
        bus.inc_pulse = 1'b0;
        check("simul_field",  {5'd0, bus.field},    8'h02);
        check("simul_hour",   bus.set_hour,         8'h05);
        load_seen = 1'b0;
        for (int i = 1; i <= 2999; i++) begin
            tick();
            load_seen = load_seen | bus.load;
            if (i == 49)  check("blink_49",  {7'd0, bus.blink_on}, 8'h00);
            if (i == 50)  check("blink_50",  {7'd0, bus.blink_on}, 8'h01);
            if (i == 100) check("blink_100", {7'd0, bus.blink_on}, 8'h00);
        end
        check("to_before",    {7'd0, bus.setting},  8'h01);
        tick();
        load_seen = load_seen | bus.load;
        check("to_setting",   {7'd0, bus.setting},  8'h00);
        check("to_field",     {5'd0, bus.field},    8'h00);
        check("to_noload",    {7'd0, load_seen},    8'h00);
        check("to_keep_min",  bus.set_min,          8'h20);

        // Held inc_level in S_MIN: auto-repeat only when the feature is built in
        set_cur(8'h00, 8'h00, 8'h23, 8'h01, 8'h01);
        press_set();
        press_set();
        bus.inc_level = 1'b1;
        repeat (100) tick();
        bus.inc_level = 1'b0;
`ifdef AUTO_REPEAT_EN
        check("repeat_min",   bus.set_min,          8'h06);
`else
        check("level_ignored", bus.set_min,         8'h00);
`endif
        exit_edit(2);
        check("final_idle",   {7'd0, bus.setting},  8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
